// File: rtl/setbit_iter_pkg.sv
// Shared definitions for the set-bit iterator family.
// Holds the default width and the IDLE/EMIT state encoding.
package setbit_iter_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic STATE_IDLE = 1'b0;
    localparam logic STATE_EMIT = 1'b1;

endpackage

// File: rtl/setbit_iter_prienc.sv
// Combinational priority encoder.
// Reports the lowest (or highest) set index and whether any bit is set.
module prienc #(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic [N-1:0]         vec,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    localparam int IW = $clog2(N);

    always_comb begin
        idx = '0;
        any = |vec;
        if (MSB_FIRST) begin
            // Ascending scan: the last hit is the highest set bit.
            for (int i = 0; i < N; i++) begin
                if (vec[i]) idx = IW'(i);
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (vec[i]) idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/setbit_iter.sv
// Enumerates the set-bit indices of an accepted vector, one beat each.
// All-zero input yields a single beat flagged with out_none.
module setbit_iter
    import setbit_iter_pkg::*;
#(
    parameter int N         = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [$clog2(N)-1:0]   out_idx,
    output logic [$clog2(N+1)-1:0] out_seq,
    output logic                   out_none,
    output logic                   out_last,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int IW = $clog2(N);
    localparam int SW = $clog2(N + 1);

    logic          state_q, state_d;
    logic [N-1:0]  vec_q, vec_d;
    logic [SW-1:0] seq_q, seq_d;

    logic [IW-1:0] scan_idx;
    logic          scan_any;
    logic          single;

    prienc #(
        .N         (N),
        .MSB_FIRST (MSB_FIRST)
    ) u_prienc (
        .vec (vec_q),
        .idx (scan_idx),
        .any (scan_any)
    );

    // True for one remaining bit and also for an empty vector.
    assign single = ((vec_q & (vec_q - N'(1))) == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= STATE_IDLE;
            vec_q   <= '0;
            seq_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            seq_q   <= seq_d;
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        seq_d   = seq_q;
        unique case (state_q)
            STATE_IDLE: begin
                if (in_valid) begin
                    vec_d   = in_data;
                    seq_d   = '0;
                    state_d = STATE_EMIT;
                end
            end
            STATE_EMIT: begin
                if (out_ready) begin
                    if (single) begin
                        vec_d   = '0;
                        seq_d   = '0;
                        state_d = STATE_IDLE;
                    end else begin
                        vec_d = vec_q & ~(N'(1) << scan_idx);
                        seq_d = seq_q + SW'(1);
                    end
                end
            end
            default: state_d = STATE_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_idx   = '0;
        out_none  = 1'b0;
        out_last  = 1'b0;
        out_seq   = seq_q;
        unique case (state_q)
            STATE_IDLE: in_ready = 1'b1;
            STATE_EMIT: begin
                out_valid = 1'b1;
                out_idx   = scan_idx;
                out_none  = ~scan_any;
                out_last  = single;
            end
            default: in_ready = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_setbit_iter.sv
// Randomised and directed bench for setbit_iter (N=8).
// Two instances (LSB-first, MSB-first) share stimulus and one queue model.
module tb_setbit_iter;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       out_ready;

    logic       l_in_ready, l_none, l_last, l_valid;
    logic [2:0] l_idx;
    logic [3:0] l_seq;
    logic       m_in_ready, m_none, m_last, m_valid;
    logic [2:0] m_idx;
    logic [3:0] m_seq;

    int n_vec = 0;
    int n_err = 0;
    int beats = 0;

    bit busy = 1'b0;
    bit mnone = 1'b0;
    int mseq = 0;
    int q_lsb[$];
    int q_msb[$];

    always #5 clk = ~clk;

    setbit_iter #(.N(N), .MSB_FIRST(1'b0)) u_lsb (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (l_in_ready),
        .out_idx   (l_idx),
        .out_seq   (l_seq),
        .out_none  (l_none),
        .out_last  (l_last),
        .out_valid (l_valid),
        .out_ready (out_ready)
    );

    setbit_iter #(.N(N), .MSB_FIRST(1'b1)) u_msb (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (m_in_ready),
        .out_idx   (m_idx),
        .out_seq   (m_seq),
        .out_none  (m_none),
        .out_last  (m_last),
        .out_valid (m_valid),
        .out_ready (out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input bit r, input bit v, input logic [7:0] d,
                       input bit ordy);
        rst       = r;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        @(negedge clk);
        chk("l_in_ready", 32'(l_in_ready), 32'(!busy));
        chk("m_in_ready", 32'(m_in_ready), 32'(!busy));
        chk("l_valid", 32'(l_valid), 32'(busy));
        chk("m_valid", 32'(m_valid), 32'(busy));
        chk("l_idx", 32'(l_idx), busy ? q_lsb[0] : 0);
        chk("m_idx", 32'(m_idx), busy ? q_msb[0] : 0);
        chk("l_seq", 32'(l_seq), busy ? mseq : 0);
        chk("m_seq", 32'(m_seq), busy ? mseq : 0);
        chk("l_last", 32'(l_last), 32'(busy && q_lsb.size() == 1));
        chk("m_last", 32'(m_last), 32'(busy && q_msb.size() == 1));
        chk("l_none", 32'(l_none), 32'(busy && mnone));
        chk("m_none", 32'(m_none), 32'(busy && mnone));
        if (r) begin
            busy = 1'b0;
            q_lsb.delete();
            q_msb.delete();
            mseq = 0;
        end else if (!busy && v) begin
            q_lsb.delete();
            q_msb.delete();
            for (int i = 0; i < N; i++) begin
                if (d[i]) begin
                    q_lsb.push_back(i);
                    q_msb.push_front(i);
                end
            end
            mnone = (q_lsb.size() == 0);
            if (mnone) begin
                q_lsb.push_back(0);
                q_msb.push_back(0);
            end
            mseq = 0;
            busy = 1'b1;
        end else if (busy && ordy) begin
            beats++;
            void'(q_lsb.pop_front());
            void'(q_msb.pop_front());
            if (q_lsb.size() == 0) begin
                busy = 1'b0;
                mseq = 0;
            end else begin
                mseq++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input logic [7:0] d, input int ncyc,
                           input int exp_beats);
        beats = 0;
        cyc(1'b0, 1'b1, d, 1'b1);
        for (int i = 0; i < ncyc; i++)
            cyc(1'b0, 1'b0, 8'($urandom), 1'b1);
        chk("beat_count", beats, exp_beats);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        cyc(1'b1, 1'b1, 8'hFF, 1'b1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);

        run_vec(8'b1010_0110, 5, 4);
        run_vec(8'h00, 2, 1);
        run_vec(8'h80, 2, 1);
        run_vec(8'h01, 2, 1);

        // All-ones with out_ready toggling.
        beats = 0;
        cyc(1'b0, 1'b1, 8'hFF, 1'b0);
        for (int i = 0; i < 18; i++)
            cyc(1'b0, 1'b0, 8'h00, (i % 2) == 0);
        chk("ff_beats", beats, 8);

        // Reset after the second beat.
        cyc(1'b0, 1'b1, 8'b1010_0110, 1'b1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        cyc(1'b1, 1'b0, 8'h00, 1'b1);
        run_vec(8'b0000_1000, 3, 1);

        // in_valid held high with churning data while emitting.
        beats = 0;
        cyc(1'b0, 1'b1, 8'b0101_1001, 1'b1);
        for (int i = 0; i < 4; i++)
            cyc(1'b0, 1'b1, 8'($urandom), ($urandom_range(0, 1) == 1) || i == 3);
        for (int i = 0; i < 6; i++)
            cyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk("hold_beats", beats, 4);

        for (int i = 0; i < 600; i++)
            cyc($urandom_range(0, 49) == 0, $urandom_range(0, 2) != 0,
                8'($urandom), $urandom_range(0, 3) != 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
